// File: rtl/wm_pkg.sv
// Shared encodings, FSM state codes and per-mode duration/cost tables for the wash controller.
package wm_pkg;

  typedef enum logic [1:0] {
    MODE_QUICK = 2'd0,
    MODE_STD   = 2'd1,
    MODE_HEAVY = 2'd2,
    MODE_SPIN  = 2'd3
  } mode_e;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_WASH  = 2'd1;
  localparam logic [1:0] PH_RINSE = 2'd2;
  localparam logic [1:0] PH_SPIN  = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_WASH   = 3'd2;
  localparam logic [2:0] ST_RINSE  = 3'd3;
  localparam logic [2:0] ST_SPIN   = 3'd4;
  localparam logic [2:0] ST_PAUSED = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  // Entry [m] belongs to mode m: quick, standard, heavy, spin-only
  localparam logic [3:0][7:0] T_WASH  = {8'd0, 8'd9, 8'd6, 8'd3};
  localparam logic [3:0][7:0] T_RINSE = {8'd0, 8'd6, 8'd4, 8'd2};
  localparam logic [3:0][7:0] T_SPIN  = {8'd3, 8'd3, 8'd2, 8'd1};
  localparam logic [3:0][7:0] COST    = {8'd2, 8'd15, 8'd10, 8'd5};

  function automatic logic [7:0] phase_dur(input logic [1:0] m, input logic [1:0] ph);
    case (ph)
      PH_WASH:  phase_dur = T_WASH[m];
      PH_RINSE: phase_dur = T_RINSE[m];
      PH_SPIN:  phase_dur = T_SPIN[m];
      default:  phase_dur = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/wash_run_if.sv
// Start/status bus between the pre-set stage, the wash controller and the display scan.
interface wash_run_if #(parameter int BAL_W = 10);
  logic             start;
  logic [BAL_W-1:0] bal_in;
  logic [1:0]       mode;
  logic             pause;
  logic [BAL_W-1:0] bal_out;
  logic             busy;
  logic [1:0]       phase;
  logic [7:0]       remain;
  logic             done;
  logic             err;

  modport master (
    output start, bal_in, mode, pause,
    input  bal_out, busy, phase, remain, done, err
  );

  modport slave (
    input  start, bal_in, mode, pause,
    output bal_out, busy, phase, remain, done, err
  );
endinterface

// File: rtl/wm_tick_gen.sv
// One-second tick divider: pulses when the count hits TICK_DIV-1 while enabled, clr restarts it.
module wm_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (en)     cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/wash_run.sv
// Wash-cycle controller: balance check, cost deduction, WASH->RINSE->SPIN countdown.
// Optional pause/resume support is compiled in with WASH_PAUSE_EN.
module wash_run
  import wm_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int BAL_W    = 10
) (
  input  logic     clk,
  input  logic     rst,
  wash_run_if.slave bus
);

  logic [2:0]       state_q, state_d;
  logic [BAL_W-1:0] bal_q, bal_out_q, cost;
  logic [1:0]       mode_q, ph_q, ph_next;
  logic [7:0]       remain_q;
  logic             err_q, in_phase, pause_req, short_bal, adv, tick, en, clr;

  function automatic logic [2:0] ph2st(input logic [1:0] ph);
    case (ph)
      PH_WASH:  ph2st = ST_WASH;
      PH_RINSE: ph2st = ST_RINSE;
      PH_SPIN:  ph2st = ST_SPIN;
      default:  ph2st = ST_DONE;
    endcase
  endfunction

`ifdef WASH_PAUSE_EN
  assign pause_req = bus.pause;
`else
  logic unused_pause;
  assign unused_pause = bus.pause;
  assign pause_req    = 1'b0;
`endif

  assign cost      = BAL_W'(COST[mode_q]);
  assign short_bal = bal_q < cost;
  assign in_phase  = (state_q == ST_WASH) || (state_q == ST_RINSE) || (state_q == ST_SPIN);
  assign ph_next   = (ph_q == PH_SPIN) ? PH_IDLE : ph_q + 2'd1;
  // A zero-length phase advances after one cycle; otherwise only the last tick of "1" does
  assign adv       = in_phase && !pause_req &&
                     ((remain_q == 8'd0) || (tick && (remain_q == 8'd1)));

  wm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_CHECK;
      ST_CHECK:  state_d = short_bal ? ST_IDLE : ST_WASH;
      ST_WASH, ST_RINSE, ST_SPIN: begin
        if (pause_req) state_d = ST_PAUSED;
        else if (adv)  state_d = ph2st(ph_next);
      end
      ST_PAUSED: if (pause_req) state_d = ph2st(ph_q);
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en        = in_phase && !pause_req;
    clr       = ((state_q == ST_CHECK) && !short_bal) || (adv && (ph_q != PH_SPIN));
    bus.busy  = in_phase || (state_q == ST_CHECK) || (state_q == ST_PAUSED);
    bus.phase = (in_phase || (state_q == ST_PAUSED)) ? ph_q : PH_IDLE;
    bus.done  = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bal_q     <= '0;
      mode_q    <= 2'd0;
      bal_out_q <= '0;
      remain_q  <= 8'd0;
      ph_q      <= PH_IDLE;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          bal_q  <= bus.bal_in;
          mode_q <= bus.mode;
          err_q  <= 1'b0;
        end
        ST_CHECK: begin
          if (short_bal) begin
            err_q     <= 1'b1;
            bal_out_q <= bal_q;
          end else begin
            bal_out_q <= bal_q - cost;
            remain_q  <= phase_dur(mode_q, PH_WASH);
            ph_q      <= PH_WASH;
          end
        end
        ST_WASH, ST_RINSE, ST_SPIN: begin
          // Leaving SPIN loads ph_next=IDLE, whose duration is 0
          if (adv) begin
            ph_q     <= ph_next;
            remain_q <= phase_dur(mode_q, ph_next);
          end else if (tick) begin
            remain_q <= remain_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bal_out = bal_out_q;
  assign bus.remain  = remain_q;
  assign bus.err     = err_q;

endmodule
